// File: rtl/par_share_arbiter_if.sv
// rtl/par_share_arbiter_if.sv - request/response bundle shared by the arbiter and its lanes
interface par_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*WORD_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_parity;
    logic                      rsp_all_ones;

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_parity,
        output rsp_all_ones
    );

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_parity,
        input  rsp_all_ones
    );
endinterface

// File: rtl/par_share_arbiter.sv
// rtl/par_share_arbiter.sv - round-robin shared parity/all-ones unit with a one-entry result buffer
// Optional saturating response statistics are enabled with PAR_SHARE_STATS_EN.
module par_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
`ifdef PAR_SHARE_STATS_EN
    ,
    parameter int CNT_W   = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    par_share_arbiter_if.slave bus
`ifdef PAR_SHARE_STATS_EN
    ,
    output logic [CNT_W-1:0]   odd_count,
    output logic [CNT_W-1:0]   ones_count
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_parity_q, rsp_parity_d;
    logic              rsp_all_ones_q, rsp_all_ones_d;

    logic              can_accept;
    logic              found;
    logic              accept;
    logic              drain;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     idx;
    logic [WORD_W-1:0] win_word;
    logic [NUM_REQ-1:0] grant;

    // Rotating search; idx carries one spare bit so the wrap works for any NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, last_grant_q} + (ID_W + 1)'(k + 1);
            if (idx >= NUM_REQ_X) begin
                idx = idx - NUM_REQ_X;
            end
            if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        can_accept = (state_q == ST_EMPTY) || bus.rsp_ready;
        grant      = '0;
        if (!rst && found && can_accept) begin
            grant[winner] = 1'b1;
        end
        accept   = |(bus.req_valid & grant);
        drain    = (state_q == ST_FULL) && bus.rsp_ready;
        win_word = bus.req_data[winner*WORD_W +: WORD_W];
    end

    // A drain and an accept in the same cycle simply overwrite the buffer.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        rsp_id_d       = rsp_id_q;
        rsp_parity_d   = rsp_parity_q;
        rsp_all_ones_d = rsp_all_ones_q;
        if (accept) begin
            state_d        = ST_FULL;
            last_grant_d   = winner;
            rsp_id_d       = winner;
            rsp_parity_d   = ^win_word;
            rsp_all_ones_d = &win_word;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_EMPTY;
            last_grant_q   <= LAST_ID;
            rsp_id_q       <= '0;
            rsp_parity_q   <= 1'b0;
            rsp_all_ones_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            rsp_id_q       <= rsp_id_d;
            rsp_parity_q   <= rsp_parity_d;
            rsp_all_ones_q <= rsp_all_ones_d;
        end
    end

    assign bus.req_ready    = grant;
    assign bus.rsp_valid    = (state_q == ST_FULL);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_parity   = rsp_parity_q;
    assign bus.rsp_all_ones = rsp_all_ones_q;

`ifdef PAR_SHARE_STATS_EN
    logic [CNT_W-1:0] odd_count_q, odd_count_d;
    logic [CNT_W-1:0] ones_count_q, ones_count_d;

    // Counted on the response handshake, so they track what downstream actually consumed.
    always_comb begin
        odd_count_d  = odd_count_q;
        ones_count_d = ones_count_q;
        if (drain && rsp_parity_q && (odd_count_q != '1)) begin
            odd_count_d = odd_count_q + 1'b1;
        end
        if (drain && rsp_all_ones_q && (ones_count_q != '1)) begin
            ones_count_d = ones_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            odd_count_q  <= '0;
            ones_count_q <= '0;
        end else begin
            odd_count_q  <= odd_count_d;
            ones_count_q <= ones_count_d;
        end
    end

    assign odd_count  = odd_count_q;
    assign ones_count = ones_count_q;
`endif

endmodule

// File: tb/tb_par_share_arbiter.sv
// tb/tb_par_share_arbiter.sv - scoreboard bench for par_share_arbiter (NUM_REQ=4, WORD_W=4)
module tb_par_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    par_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .ID_W(ID_W)) bus_if ();

`ifdef PAR_SHARE_STATS_EN
    logic [7:0] odd_count;
    logic [7:0] ones_count;
`endif

    par_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WORD_W (WORD_W),
        .ID_W   (ID_W)
`ifdef PAR_SHARE_STATS_EN
        ,
        .CNT_W  (8)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if)
`ifdef PAR_SHARE_STATS_EN
        ,
        .odd_count (odd_count),
        .ones_count(ones_count)
`endif
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {id[1:0], parity, all_ones}
    function automatic logic [3:0] rsp(input int id, input bit par, input bit ao);
        return {2'(id), par, ao};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus_if.rsp_valid && bus_if.rsp_ready) begin
            logic [3:0] got;
            logic [3:0] e;
            got = {bus_if.rsp_id, bus_if.rsp_parity, bus_if.rsp_all_ones};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got %0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL rsp_data: got id=%0d par=%0b ao=%0b expected id=%0d par=%0b ao=%0b",
                             got[3:2], got[1], got[0], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst                = 1'b1;
        bus_if.req_valid   = 4'b1111;
        bus_if.req_data    = '0;
        bus_if.rsp_ready   = 1'b1;

        // 1: reset holds everything quiet, then requester 0 wins first
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(bus_if.req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
        end
        tick();
        rst = 1'b0;
        exp_q.push_back(rsp(0, 0, 0));
        @(negedge clk);
        chk("post_rst_grant", 32'(bus_if.req_ready), 32'h1);
        tick();
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
        tick();

        // 2: single requester 2, word 1011
        bus_if.req_data  = 16'h0B00;
        bus_if.req_valid = 4'b0100;
        exp_q.push_back(rsp(2, 1, 0));
        @(negedge clk);
        chk("t2_grant", 32'(bus_if.req_ready), 32'h4);
        tick();
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        chk("t2_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
        tick();

        // 3: all valid after a fresh reset, words F/1/3/0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.req_data  = 16'h031F;
        bus_if.req_valid = 4'b1111;
        exp_q.push_back(rsp(0, 0, 1));
        exp_q.push_back(rsp(1, 1, 0));
        exp_q.push_back(rsp(2, 0, 0));
        exp_q.push_back(rsp(3, 0, 0));
        exp_q.push_back(rsp(0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3_grant%0d", i), 32'(bus_if.req_ready), 32'(1 << (i % 4)));
            tick();
        end
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        tick();

        // 4: backpressure with id1 buffered, requesters 2 and 3 waiting
        bus_if.req_valid = 4'b0010;
        bus_if.rsp_ready = 1'b0;
        exp_q.push_back(rsp(1, 1, 0));
        @(negedge clk);
        chk("t4_grant1", 32'(bus_if.req_ready), 32'h2);
        tick();
        bus_if.req_valid = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_bp_ready", 32'(bus_if.req_ready), 32'h0);
            chk("t4_bp_hold", {28'h0, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_parity},
                32'hB);
            chk("t4_bp_ao", 32'(bus_if.rsp_all_ones), 32'h0);
            tick();
        end
        bus_if.rsp_ready = 1'b1;
        exp_q.push_back(rsp(2, 0, 0));
        @(negedge clk);
        chk("t4_release_grant", 32'(bus_if.req_ready), 32'h4);
        tick();
        bus_if.req_valid = 4'b1000;
        exp_q.push_back(rsp(3, 0, 0));
        @(negedge clk);
        chk("t4_rsp_id2", 32'(bus_if.rsp_id), 32'h2);
        chk("t4_grant3", 32'(bus_if.req_ready), 32'h8);
        tick();
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        tick();

        // 5: reset discards a pending result and restores requester 0 priority
        bus_if.req_data  = 16'h031F;
        bus_if.req_valid = 4'b0001;
        bus_if.rsp_ready = 1'b0;
        @(negedge clk);
        chk("t5_grant0", 32'(bus_if.req_ready), 32'h1);
        tick();
        rst = 1'b1;
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        chk("t5_pending", 32'(bus_if.rsp_valid), 32'h1);
        tick();
        rst = 1'b0;
        bus_if.req_valid = 4'b1111;
        bus_if.rsp_ready = 1'b1;
        exp_q.push_back(rsp(0, 0, 1));
        @(negedge clk);
        chk("t5_discarded", 32'(bus_if.rsp_valid), 32'h0);
        chk("t5_first_grant", 32'(bus_if.req_ready), 32'h1);
        tick();
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        tick();

`ifdef PAR_SHARE_STATS_EN
        // 6: odd_count saturates, ones_count counts the single all-ones word
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.req_data  = 16'h0001;
        bus_if.req_valid = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(rsp(0, 1, 0));
            tick();
        end
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        tick();
        chk("t6_odd_sat", 32'(odd_count), 32'd255);
        chk("t6_ones_zero", 32'(ones_count), 32'd0);
        bus_if.req_data  = 16'h000F;
        bus_if.req_valid = 4'b0001;
        exp_q.push_back(rsp(0, 0, 1));
        tick();
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        tick();
        chk("t6_ones_one", 32'(ones_count), 32'd1);
        chk("t6_odd_hold", 32'(odd_count), 32'd255);
`endif

        repeat (2) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/par_share_arbiter.md
Name: par_share_arbiter

Overview:
Shares one parity / all-ones evaluation unit between NUM_REQ requesters.
- Each requester presents a WORD_W-bit word with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle.
- The result is captured in a single-entry output buffer, tagged with the requester ID, and drained through a valid/ready response port.
- Sits between the per-lane word sources and the downstream error-check logic.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WORD_W, 4, bits per request word
ID_W, $clog2(NUM_REQ), width of the requester ID
CNT_W, 8, width of the statistics counters (optional feature only)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  NUM_REQ*WORD_W  requester i word at [i*WORD_W +: WORD_W]
req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit set
rsp_valid  out  1  response buffer holds a result
rsp_ready  in  1  downstream accepts the response
rsp_id  out  ID_W  index of the requester that produced the result
rsp_parity  out  1  XOR reduction of the accepted word
rsp_all_ones  out  1  AND reduction of the accepted word

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values: rsp_valid=0, rsp_id=0, rsp_parity=0, rsp_all_ones=0, last_grant=NUM_REQ-1, so requester 0 has first priority. req_ready=0 while rst=1.
- Buffer states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY | (FULL & rsp_ready).
- Arbitration (combinational):
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping.
  - The first set bit is the winner.
  - req_ready[winner]=can_accept; all other req_ready bits are 0.
  - req_ready does not depend on the req_valid of non-winners.
- Accept: req_valid[w] & req_ready[w] in cycle N. On the next edge:
  - rsp_id<=w, rsp_parity<=^word, rsp_all_ones<=&word.
  - rsp_valid<=1, last_grant<=w.
  - Result visible in cycle N+1 (latency 1).
- Drain: rsp_valid & rsp_ready with no accept in the same cycle -> rsp_valid<=0 (FULL->EMPTY).
- Simultaneous drain and accept: the buffer is overwritten with the new result and rsp_valid stays 1. Sustained throughput is 1 result per cycle.
- Backpressure: FULL & !rsp_ready:
  - req_ready=0 on every bit.
  - rsp_id, rsp_parity and rsp_all_ones are held stable.
  - last_grant is unchanged.
- No valid requests: req_ready=0 and last_grant is unchanged.
- last_grant updates only on an accepted transfer.
- Fairness: a continuously-valid requester waits at most NUM_REQ-1 accepts.
- Requester contract: requesters hold req_valid and req_data until accepted. The arbiter does not check this; a dropped valid is simply skipped.
- Reset mid-operation: any buffered result is discarded (rsp_valid=0 on the next cycle) and last_grant returns to NUM_REQ-1.
- All arithmetic is unsigned.
- ID wrap: the mod NUM_REQ wrap must be correct for non-power-of-two NUM_REQ.

Optional Feature:
PAR_SHARE_STATS_EN
- Defined: adds output ports odd_count [CNT_W] and ones_count [CNT_W].
  - odd_count increments on each response handshake (rsp_valid & rsp_ready) with rsp_parity=1.
  - ones_count increments on each response handshake with rsp_all_ones=1.
  - Both saturate at all-ones and never wrap.
  - Both reset to 0 on rst.
- Undefined: the ports and counters are absent. Handshake and arbitration behaviour are unchanged.

Test Plan (NUM_REQ=4, WORD_W=4):
1. rst=1 for 2 cycles with all req_valid=1 -> req_ready=0000 and rsp_valid=0 throughout; first cycle after release: req_ready=0001.
2. Only req_valid[2]=1, word 4'b1011, rsp_ready=1 -> cycle 0: req_ready=0100; cycle 1: rsp_valid=1, rsp_id=2, rsp_parity=1, rsp_all_ones=0.
3. All valid continuously, words F/1/3/0 for req 0/1/2/3, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles. Responses:
   - id0: parity 0, all_ones 1
   - id1: parity 1, all_ones 0
   - id2: parity 0, all_ones 0
   - id3: parity 0, all_ones 0
4. Buffer FULL with id1, rsp_ready=0 for 5 cycles, req 2 and 3 valid -> req_ready=0000 and outputs stable for all 5 cycles. On the cycle rsp_ready=1: req_ready=0100, and the next cycle shows rsp_id=2.
5. rsp_valid=1 pending, 1-cycle rst pulse -> next cycle rsp_valid=0; with all valid, requester 0 is granted first.
6. PAR_SHARE_STATS_EN, CNT_W=8: 300 handshakes of word 4'b0001 -> odd_count=255 (saturated), ones_count=0. Then 4'hF once -> ones_count=1.
